// File: rtl/op_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the output-peripheral register window (addr[15:11]==WIN_TAG).
// Writes occupy 2 cycles, reads 3. Define OP_ARB_ERR_EN to add out-of-window error outputs.
module op_mem_arbiter #(
  parameter int         DATA_W  = 32,
  parameter int         ADDR_W  = 32,
  parameter logic [4:0] WIN_TAG = 5'b01110
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef OP_ARB_ERR_EN
  output logic              o_err0,
  output logic              o_err1,
  output logic              o_err_any,
`endif
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ptr;    // port favoured on a tie
  logic              r_sel, r_we, r_inwin;
  logic              r_gnt0, r_gnt1, r_rvalid0, r_rvalid1, r_mem_wren;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_rdata0, r_rdata1;
  logic              w_any_req, w_pick, w_pick_we, w_pick_inwin;
  logic [ADDR_W-1:0] w_pick_addr;
  logic [DATA_W-1:0] w_pick_wdata;
`ifdef OP_ARB_ERR_EN
  logic              r_err0, r_err1, r_err_any;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_any_req    = i_req0 | i_req1;
    w_pick       = (i_req0 && i_req1) ? r_ptr : i_req1;
    w_pick_we    = w_pick ? i_we1    : i_we0;
    w_pick_addr  = w_pick ? i_addr1  : i_addr0;
    w_pick_wdata = w_pick ? i_wdata1 : i_wdata0;
    w_pick_inwin = (w_pick_addr[15:11] == WIN_TAG);
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = r_we ? S_IDLE : S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Outputs are registered on the edge entering the state in which they must be visible.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr       <= 1'b0;
      r_sel       <= 1'b0;
      r_we        <= 1'b0;
      r_inwin     <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_mem_wren  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
`ifdef OP_ARB_ERR_EN
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_err_any   <= 1'b0;
`endif
    end else begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_mem_wren <= 1'b0;
`ifdef OP_ARB_ERR_EN
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel       <= w_pick;
            r_we        <= w_pick_we;
            r_inwin     <= w_pick_inwin;
            r_mem_addr  <= w_pick_addr;
            r_mem_wdata <= w_pick_wdata;
            r_mem_wren  <= w_pick_we & w_pick_inwin;
            if (w_pick_we) begin
              r_gnt0 <= ~w_pick;
              r_gnt1 <= w_pick;
`ifdef OP_ARB_ERR_EN
              r_err0    <= ~w_pick & ~w_pick_inwin;
              r_err1    <= w_pick & ~w_pick_inwin;
              r_err_any <= r_err_any | ~w_pick_inwin;
`endif
            end
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            r_ptr <= ~r_sel;
          end else begin
            if (r_sel) r_rdata1 <= r_inwin ? i_mem_rdata : '0;
            else       r_rdata0 <= r_inwin ? i_mem_rdata : '0;
            r_gnt0    <= ~r_sel;
            r_gnt1    <= r_sel;
            r_rvalid0 <= ~r_sel;
            r_rvalid1 <= r_sel;
`ifdef OP_ARB_ERR_EN
            r_err0    <= ~r_sel & ~r_inwin;
            r_err1    <= r_sel & ~r_inwin;
            r_err_any <= r_err_any | ~r_inwin;
`endif
          end
        end
        S_RESP:  r_ptr <= ~r_sel;
        default: ;
      endcase
    end
  end

  assign o_gnt0      = r_gnt0;
  assign o_gnt1      = r_gnt1;
  assign o_rvalid0   = r_rvalid0;
  assign o_rvalid1   = r_rvalid1;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
  assign o_mem_wren  = r_mem_wren;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state != S_IDLE);
`ifdef OP_ARB_ERR_EN
  assign o_err0      = r_err0;
  assign o_err1      = r_err1;
  assign o_err_any   = r_err_any;
`endif

endmodule

// File: tb/tb_op_mem_arbiter.sv
// Directed bench for op_mem_arbiter; outputs sampled 1 time unit after each rising edge.
module tb_op_mem_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req0 = 1'b0, i_we0 = 1'b0, i_req1 = 1'b0, i_we1 = 1'b0;
  logic [31:0] i_addr0 = '0, i_wdata0 = '0, i_addr1 = '0, i_wdata1 = '0, i_mem_rdata = '0;
  logic        o_gnt0, o_rvalid0, o_gnt1, o_rvalid1, o_mem_wren, o_busy;
  logic [31:0] o_rdata0, o_rdata1, o_mem_addr, o_mem_wdata;
`ifdef OP_ARB_ERR_EN
  logic        o_err0, o_err1, o_err_any;
`endif
  int errors = 0;
  int checks = 0;

  op_mem_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_we0(i_we0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
    .o_gnt0(o_gnt0), .o_rvalid0(o_rvalid0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .o_gnt1(o_gnt1), .o_rvalid1(o_rvalid1), .o_rdata1(o_rdata1),
    .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
`ifdef OP_ARB_ERR_EN
    .o_err0(o_err0), .o_err1(o_err1), .o_err_any(o_err_any),
`endif
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_gnt0", o_gnt0, 0);       chk("rst_gnt1", o_gnt1, 0);
    chk("rst_rvalid0", o_rvalid0, 0); chk("rst_rvalid1", o_rvalid1, 0);
    chk("rst_wren", o_mem_wren, 0);   chk("rst_addr", o_mem_addr, 0);
    chk("rst_wdata", o_mem_wdata, 0); chk("rst_rdata0", o_rdata0, 0);
    chk("rst_rdata1", o_rdata1, 0);   chk("rst_busy", o_busy, 0);
    i_rst = 1'b1;
    tick();
    chk("idle_busy", o_busy, 0);

    // Port 0 in-window write
    i_req0 = 1; i_we0 = 1; i_addr0 = 32'h7000; i_wdata0 = 32'h0000_00A5;
    tick();
    chk("w0_wren", o_mem_wren, 1); chk("w0_addr", o_mem_addr, 32'h7000);
    chk("w0_wdata", o_mem_wdata, 32'hA5); chk("w0_gnt0", o_gnt0, 1);
    chk("w0_gnt1", o_gnt1, 0); chk("w0_busy", o_busy, 1);
`ifdef OP_ARB_ERR_EN
    chk("w0_err0", o_err0, 0);
`endif
    i_req0 = 0;
    tick();
    chk("w0_wren_off", o_mem_wren, 0); chk("w0_gnt_off", o_gnt0, 0);
    chk("w0_busy_off", o_busy, 0); chk("w0_addr_hold", o_mem_addr, 32'h7000);

    // Port 1 in-window read
    i_req1 = 1; i_we1 = 0; i_addr1 = 32'h7020; i_mem_rdata = 32'h3F06_5B4F;
    tick();
    chk("r1_issue_gnt1", o_gnt1, 0); chk("r1_issue_rv1", o_rvalid1, 0);
    chk("r1_issue_wren", o_mem_wren, 0); chk("r1_issue_addr", o_mem_addr, 32'h7020);
    chk("r1_issue_busy", o_busy, 1);
    tick();
    chk("r1_gnt1", o_gnt1, 1); chk("r1_rv1", o_rvalid1, 1);
    chk("r1_rdata1", o_rdata1, 32'h3F06_5B4F); chk("r1_rv0", o_rvalid0, 0);
    chk("r1_gnt0", o_gnt0, 0); chk("r1_busy", o_busy, 1);
    i_req1 = 0; i_mem_rdata = 32'h0;
    tick();
    chk("r1_rv1_off", o_rvalid1, 0); chk("r1_rdata1_hold", o_rdata1, 32'h3F06_5B4F);
    chk("r1_busy_off", o_busy, 0);

    // Both ports write continuously: grants alternate 0,1,0,1
    i_req0 = 1; i_we0 = 1; i_addr0 = 32'h7004; i_wdata0 = 32'h11;
    i_req1 = 1; i_we1 = 1; i_addr1 = 32'h7008; i_wdata1 = 32'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt_gnt0", o_gnt0, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_gnt1", o_gnt1, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("alt_wren", o_mem_wren, 1);
      chk("alt_addr", o_mem_addr, (k % 2 == 0) ? 32'h7004 : 32'h7008);
      chk("alt_wdata", o_mem_wdata, (k % 2 == 0) ? 32'h11 : 32'h22);
      tick();
      chk("alt_idle_gnt", {30'd0, o_gnt0, o_gnt1}, 0);
      chk("alt_idle_wren", o_mem_wren, 0);
    end
    i_req0 = 0; i_req1 = 0;
    tick();
    chk("alt_done_busy", o_busy, 0);

    // Out-of-window write and read on port 0
    i_req0 = 1; i_we0 = 1; i_addr0 = 32'h8000; i_wdata0 = 32'h55;
    tick();
    chk("oow_w_gnt0", o_gnt0, 1); chk("oow_w_wren", o_mem_wren, 0);
    chk("oow_w_addr", o_mem_addr, 32'h8000);
`ifdef OP_ARB_ERR_EN
    chk("oow_w_err0", o_err0, 1); chk("oow_w_err_any", o_err_any, 1);
`endif
    i_req0 = 0;
    tick();
    i_req0 = 1; i_we0 = 0; i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("oow_r_wren", o_mem_wren, 0);
    tick();
    chk("oow_r_gnt0", o_gnt0, 1); chk("oow_r_rv0", o_rvalid0, 1);
    chk("oow_r_rdata0", o_rdata0, 0);
`ifdef OP_ARB_ERR_EN
    chk("oow_r_err0", o_err0, 1); chk("oow_r_err_any", o_err_any, 1);
`endif
    i_req0 = 0;
    tick();
    chk("oow_r_busy_off", o_busy, 0);

    // Port 1 request withdrawn before grant while port 0 reads
    i_req0 = 1; i_we0 = 0; i_addr0 = 32'h7010; i_mem_rdata = 32'h1234_5678;
    tick();
    i_req1 = 1; i_we1 = 1; i_addr1 = 32'h7040; i_wdata1 = 32'h99;
    tick();
    chk("drop_gnt0", o_gnt0, 1); chk("drop_rv0", o_rvalid0, 1);
    chk("drop_rdata0", o_rdata0, 32'h1234_5678); chk("drop_gnt1", o_gnt1, 0);
    i_req0 = 0; i_req1 = 0;
    tick();
    chk("drop_idle_busy", o_busy, 0);
    tick();
    chk("drop_no_issue_busy", o_busy, 0); chk("drop_no_wren", o_mem_wren, 0);
    chk("drop_no_gnt1", o_gnt1, 0); chk("drop_addr_hold", o_mem_addr, 32'h7010);

    // Reset during RESP of a port 1 read
    i_req1 = 1; i_we1 = 0; i_addr1 = 32'h7030; i_mem_rdata = 32'hCAFE_F00D;
    tick(); tick();
    chk("rr_rv1", o_rvalid1, 1); chk("rr_rdata1", o_rdata1, 32'hCAFE_F00D);
    i_rst = 0; i_req1 = 0;
    tick();
    chk("rr_gnt1", o_gnt1, 0); chk("rr_rv1_off", o_rvalid1, 0);
    chk("rr_rdata1", o_rdata1, 0); chk("rr_rdata0", o_rdata0, 0);
    chk("rr_addr", o_mem_addr, 0); chk("rr_wdata", o_mem_wdata, 0);
    chk("rr_wren", o_mem_wren, 0); chk("rr_busy", o_busy, 0);
`ifdef OP_ARB_ERR_EN
    chk("rr_err_any", o_err_any, 0);
`endif
    tick();
    i_rst = 1;
    chk("rr_hold_rv1", o_rvalid1, 0);

    // First post-reset tie goes to port 0
    i_req0 = 1; i_we0 = 1; i_addr0 = 32'h7044; i_wdata0 = 32'h44;
    i_req1 = 1; i_we1 = 1; i_addr1 = 32'h7048; i_wdata1 = 32'h48;
    tick();
    chk("tie_gnt0", o_gnt0, 1); chk("tie_gnt1", o_gnt1, 0);
    chk("tie_addr", o_mem_addr, 32'h7044);
    i_req0 = 0;
    tick();
    tick();
    chk("tie2_gnt1", o_gnt1, 1); chk("tie2_gnt0", o_gnt0, 0);
    chk("tie2_addr", o_mem_addr, 32'h7048);
    i_req1 = 0;
    tick();
    chk("end_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
